// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER fetch stage and the stages that consume IF/ID.
// Holds the default constants, the IF/ID layout and the fetch-fault predicate.
package otter_pkg;

    localparam logic [31:0] RESET_VEC  = 32'h0000_0000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0001_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ir;
        logic        valid;
        logic        fault;
    } if_id_t;

    // Misaligned PCs and PCs in the MMIO region are not legal fetch addresses
    function automatic logic fetch_fault(input logic [31:0] pc, input logic [31:0] limit);
        return (pc[1:0] != 2'b00) || (pc >= limit);
    endfunction

endpackage

// File: rtl/otter_pc_reg.sv
// Program counter with its next-PC priority mux: reset, redirect, stall, then sequential.
// Flush and normal fetch both advance by 4, so they share the default path.
module otter_pc_reg #(
    parameter logic [31:0] RESET_VEC = otter_pkg::RESET_VEC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (i_br_taken) begin
            w_pc_next = i_br_target;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: drives the Memory instruction port and fills the IF/ID register.
// Memory reads on the negedge, so the word for the current PC is captured at the next posedge.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VEC  = otter_pkg::RESET_VEC,
    parameter logic [31:0] IMEM_LIMIT = otter_pkg::IMEM_LIMIT,
    parameter logic [31:0] NOP_INSTR  = otter_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL_IF,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        FLUSH_ID,
    input  logic [31:0] MEM_DOUT1,
    output logic [13:0] MEM_ADDR1,
    output logic        MEM_RDEN1,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_IR,
    output logic        IF_ID_VALID,
    output logic        IF_ID_FAULT,
    output logic [31:0] FETCH_CNT
);

    import otter_pkg::*;

    logic [31:0] w_pc;
    logic        w_fault;
    logic        r_fetch_live;
    if_id_t      r_if_id;
    logic [31:0] r_fetch_cnt;

    otter_pc_reg #(
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_stall     (STALL_IF),
        .i_br_taken  (BR_TAKEN),
        .i_br_target (BR_TARGET),
        .o_pc        (w_pc)
    );

    assign w_fault   = fetch_fault(w_pc, IMEM_LIMIT);
    assign MEM_ADDR1 = w_pc[15:2];
    assign MEM_RDEN1 = ~STALL_IF | BR_TAKEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_if_id      <= '{pc: 32'd0, pc4: 32'd0, ir: NOP_INSTR, valid: 1'b0, fault: 1'b0};
            r_fetch_live <= 1'b0;
            r_fetch_cnt  <= 32'd0;
        end else begin
            r_fetch_live <= 1'b1;
            if (BR_TAKEN) begin
                r_if_id.valid <= 1'b0;
                r_if_id.ir    <= NOP_INSTR;
            end else if (!STALL_IF) begin
                if (FLUSH_ID) begin
                    r_if_id.valid <= 1'b0;
                    r_if_id.ir    <= NOP_INSTR;
                end else begin
                    r_if_id.pc    <= w_pc;
                    r_if_id.pc4   <= w_pc + 32'd4;
                    // Faulting fetches carry a NOP so MMIO/garbage data never reaches decode
                    r_if_id.ir    <= w_fault ? NOP_INSTR : MEM_DOUT1;
                    r_if_id.valid <= r_fetch_live;
                    r_if_id.fault <= w_fault;
                    if (r_fetch_live) begin
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                    end
                end
            end
        end
    end

    assign IF_ID_PC    = r_if_id.pc;
    assign IF_ID_PC4   = r_if_id.pc4;
    assign IF_ID_IR    = r_if_id.ir;
    assign IF_ID_VALID = r_if_id.valid;
    assign IF_ID_FAULT = r_if_id.fault;
    assign FETCH_CNT   = r_fetch_cnt;

endmodule
